// File: rtl/lpc_io_decode.sv
// -----------------------------------------------------------------------------
// lpc_io_decode
//
// LPC I/O-cycle target front end. Follows LPC frames on LFRAME#/LAD and claims
// host I/O reads and writes that land inside a 2^WIN_BITS byte window at
// BASE_ADDR. It publishes the register offset to the read-data mux, returns
// the mux output on LAD for reads, and presents a write byte with a
// one-clock strobe for writes.
//
// Optional build macro:
//   LPC_SYNC_WAIT_EN - inserts two short-wait SYNC nibbles (4'h5) ahead of the
//                      ready SYNC on both reads and writes.
//
// Ports:
//   LpcClock  in   33 MHz LPC clock
//   PciReset  in   asynchronous, active-low reset
//   LFrame_n  in   LFRAME#
//   LadIn     in   sampled LAD[3:0]
//   LadOut    out  value driven onto LAD (4'hF when not driving)
//   LadOe     out  LAD output enable
//   AddrReg   out  register offset {zero pad, addr[WIN_BITS-1:0]}
//   DataRd    in   registered read data from the mux (follows AddrReg by 1 clk)
//   DataWr    out  write data byte
//   WrStrobe  out  one-clock write pulse, during the ready SYNC of a write
//   RdStrobe  out  one-clock read-done pulse, during the high data nibble
// -----------------------------------------------------------------------------
module lpc_io_decode #(
   parameter logic [15:0] BASE_ADDR = 16'h0800,
   parameter int          WIN_BITS  = 5
) (
   input  logic       LpcClock,
   input  logic       PciReset,
   input  logic       LFrame_n,
   input  logic [3:0] LadIn,
   output logic [3:0] LadOut,
   output logic       LadOe,
   output logic [7:0] AddrReg,
   input  logic [7:0] DataRd,
   output logic [7:0] DataWr,
   output logic       WrStrobe,
   output logic       RdStrobe
);

   typedef enum logic [4:0] {
      ST_IDLE,
      ST_CYC,
      ST_ADDR0,
      ST_ADDR1,
      ST_ADDR2,
      ST_ADDR3,
      ST_WDATA0,
      ST_WDATA1,
      ST_HTAR0,
      ST_HTAR1,
      ST_SYNC_W0,
      ST_SYNC_W1,
      ST_SYNC,
      ST_RDATA0,
      ST_RDATA1,
      ST_PTAR0,
      ST_PTAR1
   } state_t;

   state_t      state_q,    state_d;
   logic        is_write_q, is_write_d;
   logic [11:0] addr_q,     addr_d;      // first three address nibbles
   logic [7:0]  addr_reg_q, addr_reg_d;
   logic [7:0]  data_wr_q,  data_wr_d;
   logic [7:0]  rd_hold_q,  rd_hold_d;

   // Full address as it stands once the current nibble is shifted in; only
   // meaningful on the last address clock, where the window decision is made.
   logic [15:0] addr_shift;
   logic        win_hit;
   logic [7:0]  offset;

   assign addr_shift = {addr_q, LadIn};
   assign win_hit    = (addr_shift[15:WIN_BITS] == BASE_ADDR[15:WIN_BITS]);

   // Offset byte: window bits of the address, upper bits forced to zero.
   for (genvar gi = 0; gi < 8; gi++) begin : g_offset
      if (gi < WIN_BITS) begin : g_win
         assign offset[gi] = addr_shift[gi];
      end else begin : g_pad
         assign offset[gi] = 1'b0;
      end
   end

   // Next-state and register update logic
   always_comb begin
      state_d    = state_q;
      is_write_d = is_write_q;
      addr_d     = addr_q;
      addr_reg_d = addr_reg_q;
      data_wr_d  = data_wr_q;
      rd_hold_d  = rd_hold_q;

      if (!LFrame_n) begin
         // LFRAME# low always ends whatever was in flight. LAD=0 is a START,
         // so back-to-back STARTs simply restart at the cycle-type clock.
         state_d = (LadIn == 4'h0) ? ST_CYC : ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_CYC: begin
               if (LadIn == 4'h0) begin
                  is_write_d = 1'b0;
                  state_d    = ST_ADDR0;
               end else if (LadIn == 4'h2) begin
                  is_write_d = 1'b1;
                  state_d    = ST_ADDR0;
               end else begin
                  // Memory, DMA, FWH: not ours, sit out the frame.
                  state_d = ST_IDLE;
               end
            end
            ST_ADDR0: begin
               addr_d  = addr_shift[11:0];
               state_d = ST_ADDR1;
            end
            ST_ADDR1: begin
               addr_d  = addr_shift[11:0];
               state_d = ST_ADDR2;
            end
            ST_ADDR2: begin
               addr_d  = addr_shift[11:0];
               state_d = ST_ADDR3;
            end
            ST_ADDR3: begin
               addr_d = addr_shift[11:0];
               if (win_hit) begin
                  // Loading here gives the mux one clock to register DataRd
                  // before the earliest point it is sampled.
                  addr_reg_d = offset;
                  state_d    = is_write_q ? ST_WDATA0 : ST_HTAR0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_WDATA0: begin
               data_wr_d[3:0] = LadIn;
               state_d        = ST_WDATA1;
            end
            ST_WDATA1: begin
               data_wr_d[7:4] = LadIn;
               state_d        = ST_HTAR0;
            end
            ST_HTAR0: state_d = ST_HTAR1;
            ST_HTAR1: begin
`ifdef LPC_SYNC_WAIT_EN
               state_d = ST_SYNC_W0;
`else
               state_d = ST_SYNC;
`endif
            end
            ST_SYNC_W0: state_d = ST_SYNC_W1;
            ST_SYNC_W1: state_d = ST_SYNC;
            ST_SYNC: begin
               if (is_write_q) begin
                  state_d = ST_PTAR0;
               end else begin
                  // Freeze the read byte so LAD cannot change mid-transfer.
                  rd_hold_d = DataRd;
                  state_d   = ST_RDATA0;
               end
            end
            ST_RDATA0: state_d = ST_RDATA1;
            ST_RDATA1: state_d = ST_PTAR0;
            ST_PTAR0:  state_d = ST_PTAR1;
            ST_PTAR1:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge LpcClock or negedge PciReset) begin
      if (!PciReset) begin
         state_q    <= ST_IDLE;
         is_write_q <= 1'b0;
         addr_q     <= 12'h000;
         addr_reg_q <= 8'h00;
         data_wr_q  <= 8'h00;
         rd_hold_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         is_write_q <= is_write_d;
         addr_q     <= addr_d;
         addr_reg_q <= addr_reg_d;
         data_wr_q  <= data_wr_d;
         rd_hold_q  <= rd_hold_d;
      end
   end

   // LAD drive and strobes decode only from registered state, so they move
   // strictly on clock edges and are glitch-free toward the pins.
   always_comb begin
      LadOut   = 4'hF;
      LadOe    = 1'b0;
      WrStrobe = 1'b0;
      RdStrobe = 1'b0;
      case (state_q)
         ST_SYNC_W0, ST_SYNC_W1: begin
            LadOut = 4'h5;
            LadOe  = 1'b1;
         end
         ST_SYNC: begin
            LadOut   = 4'h0;
            LadOe    = 1'b1;
            WrStrobe = is_write_q;
         end
         ST_RDATA0: begin
            LadOut = rd_hold_q[3:0];
            LadOe  = 1'b1;
         end
         ST_RDATA1: begin
            LadOut   = rd_hold_q[7:4];
            LadOe    = 1'b1;
            RdStrobe = 1'b1;
         end
         ST_PTAR0: begin
            LadOut = 4'hF;
            LadOe  = 1'b1;
         end
         default: begin
            LadOut = 4'hF;
            LadOe  = 1'b0;
         end
      endcase
   end

   assign AddrReg = addr_reg_q;
   assign DataWr  = data_wr_q;

endmodule

// File: tb/tb_lpc_io_decode.sv
// -----------------------------------------------------------------------------
// tb_lpc_io_decode
//
// Directed bench for lpc_io_decode. Frames are built as nibble sequences and
// played one per clock; the outputs seen in each clock of a frame are logged
// by frame-cycle index for literal checks. A cycle-count model of the LPC
// protocol predicts every output on every clock.
// -----------------------------------------------------------------------------
module tb_lpc_io_decode;

`ifdef LPC_SYNC_WAIT_EN
   localparam int W = 2;
`else
   localparam int W = 0;
`endif
   localparam logic [15:0] BASE = 16'h0800;

   logic       LpcClock = 1'b0;
   logic       PciReset = 1'b1;
   logic       LFrame_n = 1'b1;
   logic [3:0] LadIn    = 4'hF;
   logic [3:0] LadOut;
   logic       LadOe;
   logic [7:0] AddrReg;
   logic [7:0] DataRd   = 8'h00;
   logic [7:0] DataWr;
   logic       WrStrobe;
   logic       RdStrobe;

   lpc_io_decode #(.BASE_ADDR(BASE), .WIN_BITS(5)) dut (
      .LpcClock (LpcClock),
      .PciReset (PciReset),
      .LFrame_n (LFrame_n),
      .LadIn    (LadIn),
      .LadOut   (LadOut),
      .LadOe    (LadOe),
      .AddrReg  (AddrReg),
      .DataRd   (DataRd),
      .DataWr   (DataWr),
      .WrStrobe (WrStrobe),
      .RdStrobe (RdStrobe)
   );

   always #5 LpcClock = ~LpcClock;

   // Register file behind the read mux: DataRd follows AddrReg by one clock.
   logic [7:0] regs [0:255];
   always @(posedge LpcClock) DataRd <= regs[AddrReg];

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- protocol model -----------------
   int         m_n    = -1;    // cycle number within the current frame, -1 = none
   bit         m_wr   = 1'b0;
   logic [15:0] m_a   = 16'h0;
   logic [7:0] m_addr = 8'h00;
   logic [7:0] m_dw   = 8'h00;
   logic [7:0] m_hold = 8'h00;

   always @(posedge LpcClock or negedge PciReset) begin
      int nn;
      if (!PciReset) begin
         m_n = -1; m_wr = 1'b0; m_a = 16'h0;
         m_addr = 8'h00; m_dw = 8'h00; m_hold = 8'h00;
      end else begin
         nn = (m_n < 0) ? -1 : m_n + 1;
         if (!LFrame_n) begin
            nn = (LadIn == 4'h0) ? 1 : -1;
         end else begin
            if (m_n == 1) begin
               if (LadIn == 4'h0) m_wr = 1'b0;
               else if (LadIn == 4'h2) m_wr = 1'b1;
               else nn = -1;
            end else if (m_n >= 2 && m_n <= 5) begin
               m_a = {m_a[11:0], LadIn};
               if (m_n == 5) begin
                  if (m_a[15:5] == BASE[15:5]) m_addr = {3'b000, m_a[4:0]};
                  else nn = -1;
               end
            end else if (m_wr && m_n == 6) begin
               m_dw[3:0] = LadIn;
            end else if (m_wr && m_n == 7) begin
               m_dw[7:4] = LadIn;
            end else if (!m_wr && m_n == 8 + W) begin
               m_hold = DataRd;
            end
            if (m_n == 12 + W) nn = -1;
         end
         m_n = nn;
      end
   end

   // Every-clock comparison against the model
   bit chk_en = 1'b0;
   always @(negedge LpcClock) begin
      int s, r;
      logic       e_oe, e_rs, e_ws;
      logic [3:0] e_out;
      if (chk_en) begin
         s = m_wr ? 10 : 8;
         r = s + W;                      // ready SYNC clock
         e_oe  = (m_n >= s) && (m_n <= (m_wr ? r + 1 : r + 3));
         e_out = 4'hF;
         if (m_n >= s && m_n < r) e_out = 4'h5;
         else if (m_n == r) e_out = 4'h0;
         else if (!m_wr && m_n == r + 1) e_out = m_hold[3:0];
         else if (!m_wr && m_n == r + 2) e_out = m_hold[7:4];
         e_rs = !m_wr && (m_n == r + 2);
         e_ws = m_wr && (m_n == r);
         chk("cmp_LadOut",   {4'h0, LadOut},   {4'h0, e_out});
         chk("cmp_LadOe",    {7'h0, LadOe},    {7'h0, e_oe});
         chk("cmp_RdStrobe", {7'h0, RdStrobe}, {7'h0, e_rs});
         chk("cmp_WrStrobe", {7'h0, WrStrobe}, {7'h0, e_ws});
         chk("cmp_AddrReg",  AddrReg, m_addr);
         chk("cmp_DataWr",   DataWr,  m_dw);
      end
   end

   // ---------------- stimulus helpers -----------------
   bit         seq_lf  [$];
   logic [3:0] seq_lad [$];
   logic [3:0] obs_out  [0:63];
   logic       obs_oe   [0:63];
   logic       obs_rs   [0:63];
   logic       obs_ws   [0:63];
   logic [7:0] obs_addr [0:63];
   logic [7:0] obs_dw   [0:63];
   int         seq_len;

   task automatic push(input bit lf, input logic [3:0] lad);
      seq_lf.push_back(lf);
      seq_lad.push_back(lad);
   endtask

   task automatic push_hdr(input bit wr, input logic [15:0] a);
      push(1'b0, 4'h0);
      push(1'b1, wr ? 4'h2 : 4'h0);
      push(1'b1, a[15:12]);
      push(1'b1, a[11:8]);
      push(1'b1, a[7:4]);
      push(1'b1, a[3:0]);
   endtask

   task automatic push_idle(input int count);
      for (int i = 0; i < count; i++) push(1'b1, 4'hF);
   endtask

   // obs_*[i] holds what the DUT showed during the clock whose inputs are
   // seq[i], i.e. frame cycle i when seq starts with a START.
   task automatic play(input string tag);
      seq_len = seq_lf.size();
      for (int i = 0; i < seq_len; i++) begin
         @(negedge LpcClock);
         obs_out[i]  = LadOut;
         obs_oe[i]   = LadOe;
         obs_rs[i]   = RdStrobe;
         obs_ws[i]   = WrStrobe;
         obs_addr[i] = AddrReg;
         obs_dw[i]   = DataWr;
         LFrame_n = seq_lf[i];
         LadIn    = seq_lad[i];
      end
      seq_lf.delete();
      seq_lad.delete();
      $display("transaction %s: %0d clocks played", tag, seq_len);
   endtask

   task automatic chk_no_drive(input string name);
      logic any_oe, any_st;
      any_oe = 1'b0;
      any_st = 1'b0;
      for (int i = 0; i < seq_len; i++) begin
         any_oe = any_oe | obs_oe[i];
         any_st = any_st | obs_rs[i] | obs_ws[i];
      end
      chk({name, "_oe"},     {7'h0, any_oe}, 8'h00);
      chk({name, "_strobe"}, {7'h0, any_st}, 8'h00);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) regs[i] = 8'(i) ^ 8'h3C;
      regs[8'h0E] = 8'hA5;
      regs[8'h00] = 8'h96;
      regs[8'h05] = 8'h5A;

      // ---- reset ----
      #1 PciReset = 1'b0;
      chk_en = 1'b1;
      @(negedge LpcClock);
      chk("rst_LadOe",   {7'h0, LadOe}, 8'h00);
      chk("rst_LadOut",  {4'h0, LadOut}, 8'h0F);
      chk("rst_AddrReg", AddrReg, 8'h00);
      chk("rst_DataWr",  DataWr, 8'h00);
      chk("rst_strobes", {6'h0, WrStrobe, RdStrobe}, 8'h00);
      @(negedge LpcClock);
      PciReset = 1'b1;
      $display("transaction reset: released");
      push_idle(2);
      play("idle");

      // ---- read 0x080E, data A5 ----
      push_hdr(1'b0, 16'h080E);
      push_idle(9 + W);
      play("read 080E");
      chk("rd_addr_c6",  obs_addr[6], 8'h0E);
      chk("rd_sync",     {4'h0, obs_out[8 + W]},  8'h00);
      chk("rd_lo",       {4'h0, obs_out[9 + W]},  8'h05);
      chk("rd_hi",       {4'h0, obs_out[10 + W]}, 8'h0A);
      chk("rd_tar",      {4'h0, obs_out[11 + W]}, 8'h0F);
      chk("rd_oe_c11",   {7'h0, obs_oe[11 + W]},  8'h01);
      chk("rd_oe_c12",   {7'h0, obs_oe[12 + W]},  8'h00);
      chk("rd_rs_c9",    {7'h0, obs_rs[9 + W]},   8'h00);
      chk("rd_rs_c10",   {7'h0, obs_rs[10 + W]},  8'h01);
      chk("rd_rs_c11",   {7'h0, obs_rs[11 + W]},  8'h00);

`ifdef LPC_SYNC_WAIT_EN
      // ---- read 0x0800 with wait SYNCs, data 96 ----
      push_hdr(1'b0, 16'h0800);
      push_idle(11);
      play("read 0800 wait");
      chk("wt_c8",  {4'h0, obs_out[8]},  8'h05);
      chk("wt_c9",  {4'h0, obs_out[9]},  8'h05);
      chk("wt_c10", {4'h0, obs_out[10]}, 8'h00);
      chk("wt_c11", {4'h0, obs_out[11]}, 8'h06);
      chk("wt_c12", {4'h0, obs_out[12]}, 8'h09);
      chk("wt_c13", {4'h0, obs_out[13]}, 8'h0F);
`endif

      // ---- write 0x3C to 0x0801 ----
      push_hdr(1'b1, 16'h0801);
      push(1'b1, 4'hC);
      push(1'b1, 4'h3);
      push_idle(7 + W);
      play("write 0801=3C");
      chk("wr_ws_c9",   {7'h0, obs_ws[9 + W]},  8'h00);
      chk("wr_ws_c10",  {7'h0, obs_ws[10 + W]}, 8'h01);
      chk("wr_ws_c11",  {7'h0, obs_ws[11 + W]}, 8'h00);
      chk("wr_data",    obs_dw[10 + W],   8'h3C);
      chk("wr_addr",    obs_addr[10 + W], 8'h01);
      chk("wr_sync",    {4'h0, obs_out[10 + W]}, 8'h00);
      chk("wr_tar",     {4'h0, obs_out[11 + W]}, 8'h0F);
      chk("wr_oe_c11",  {7'h0, obs_oe[11 + W]},  8'h01);
      chk("wr_oe_c12",  {7'h0, obs_oe[12 + W]},  8'h00);

      // ---- miss at 0x0820 ----
      push_hdr(1'b0, 16'h0820);
      push_idle(10);
      play("read 0820 miss");
      chk_no_drive("miss");
      chk("miss_addr", obs_addr[seq_len - 1], 8'h01);

      // ---- cycle type 4 (memory) ----
      push(1'b0, 4'h0);
      push(1'b1, 4'h4);
      push(1'b1, 4'h0); push(1'b1, 4'h8); push(1'b1, 4'h0); push(1'b1, 4'h1);
      push_idle(10);
      play("memory cyctype");
      chk_no_drive("cyc4");
      chk("cyc4_addr", obs_addr[seq_len - 1], 8'h01);

      // ---- write aborted at cycle 7 by a new START, then read 0x0805 ----
      push_hdr(1'b1, 16'h0803);
      push(1'b1, 4'h7);
      push(1'b0, 4'h0);              // index 7: abort + new START
      push(1'b1, 4'h0);              // read
      push(1'b1, 4'h0); push(1'b1, 4'h8); push(1'b1, 4'h0); push(1'b1, 4'h5);
      push_idle(9 + W);
      play("aborted write + read 0805");
      begin
         logic any_ws;
         any_ws = 1'b0;
         for (int i = 0; i < seq_len; i++) any_ws = any_ws | obs_ws[i];
         chk("abort_no_ws", {7'h0, any_ws}, 8'h00);
      end
      chk("abort_addr_c6",  obs_addr[6], 8'h03);
      chk("abort_dw",       obs_dw[seq_len - 1], 8'h37);
      chk("abort_rd_addr",  obs_addr[13], 8'h05);
      chk("abort_rd_sync",  {4'h0, obs_out[15 + W]}, 8'h00);
      chk("abort_rd_lo",    {4'h0, obs_out[16 + W]}, 8'h0A);
      chk("abort_rd_hi",    {4'h0, obs_out[17 + W]}, 8'h05);

      // ---- reset during cycle 9 of a read ----
      push_hdr(1'b0, 16'h0807);
      push_idle(3);
      play("read 0807 reset");
      chk("prerst_addr", obs_addr[8], 8'h07);
      @(posedge LpcClock);           // start of cycle 9
      #2 PciReset = 1'b0;
      #1;
      chk("midrst_oe",   {7'h0, LadOe}, 8'h00);
      chk("midrst_addr", AddrReg, 8'h00);
      @(negedge LpcClock);
      @(negedge LpcClock);
      PciReset = 1'b1;
      $display("transaction reset: released after mid-read reset");
      push_idle(3);
      play("idle");

      // ---- recovery read ----
      push_hdr(1'b0, 16'h080E);
      push_idle(9 + W);
      play("read 080E again");
      chk("rec_hi", {4'h0, obs_out[10 + W]}, 8'h0A);
      chk("rec_lo", {4'h0, obs_out[9 + W]},  8'h05);

      push_idle(2);
      play("idle");
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/lpc_io_decode.md
Name: lpc_io_decode

Overview:
- LPC I/O-cycle target front end between the LPC pins and the CPLD register file.
- Decodes host I/O read and write cycles that hit a 32-byte window.
- Publishes the register offset as AddrReg to the downstream read-data mux. That mux registers DataRd one LpcClock after AddrReg changes.
- Returns DataRd on LAD for reads; presents DataWr with a one-cycle WrStrobe for writes.

Parameters:
BASE_ADDR, 16'h0800, I/O base address of the window; bits [4:0] are ignored.
WIN_BITS, 5, number of low address bits forming the offset (window = 2^WIN_BITS bytes).

Ports:
LpcClock  in  1  33 MHz LPC clock
PciReset  in  1  asynchronous, active-low reset
LFrame_n  in  1  LPC LFRAME#
LadIn  in  4  sampled LAD[3:0]
LadOut  out  4  value driven onto LAD
LadOe  out  1  LAD output enable
AddrReg  out  8  register offset, {zero-pad, addr[WIN_BITS-1:0]}
DataRd  in  8  registered read data from the mux
DataWr  out  8  write data byte
WrStrobe  out  1  one-clock write pulse
RdStrobe  out  1  one-clock read-done pulse, for read-clear registers

Behaviour:
- Reset: PciReset asynchronous, active-low; clock LpcClock. While reset is low: state=IDLE, LadOe=0, LadOut=4'hF, AddrReg=8'h00, DataWr=8'h00, WrStrobe=0, RdStrobe=0.
- States: IDLE, CYC, ADDR(×4), WDATA(×2), HTAR(×2), SYNC, RDATA(×2), PTAR0, PTAR1.
- LadOut and LadOe are decoded from the registered state, so they change only on a clock edge.
- Cycle numbering: cycle 0 is the last clock with LFrame_n=0 and LadIn=4'h0 (START).
  - Consecutive START clocks restart the count.
  - START with LadIn≠0 → stay IDLE.
- Cycle 1 (CYC): LadIn=4'h0 → read; LadIn=4'h2 → write. Any other value (memory, DMA, FWH) → IDLE for the rest of the frame; no drive.
- Cycles 2–5 (ADDR): address nibbles, MSB first, shifted into a 16-bit register.
  - At end of cycle 5, hit = (addr[15:WIN_BITS] == BASE_ADDR[15:WIN_BITS]).
  - Miss → IDLE; AddrReg unchanged.
  - Hit → AddrReg loaded at the cycle-5 edge. It is valid in cycle 6, so DataRd is valid from cycle 7.
- Read hit:
  - Cycles 6–7: HTAR, no drive.
  - Cycle 8: SYNC, LadOut=4'h0, LadOe=1. DataRd is captured into a hold register.
  - Cycles 9–10: low nibble, then high nibble.
  - Cycle 11: LadOut=4'hF, LadOe=1.
  - Cycle 12: LadOe=0, then IDLE.
  - RdStrobe=1 for cycle 10 only.
- Write hit:
  - Cycles 6–7: data nibbles, low nibble first, into DataWr.
  - Cycles 8–9: HTAR, no drive.
  - Cycle 10: SYNC=4'h0 driven; WrStrobe=1 during cycle 10 only; DataWr and AddrReg stable.
  - Cycle 11: drive 4'hF.
  - Cycle 12: release, then IDLE.
- Abort: LFrame_n=0 in any non-IDLE state ends the cycle.
  - LadOe=0 from the next edge; no strobe is issued.
  - If LadIn=4'h0 on that clock, it is treated as a new START (next state CYC); otherwise next state IDLE.
  - A write aborted before cycle 10 leaves DataWr partially updated but issues no WrStrobe.
- DataWr and AddrReg hold their last values between cycles.
- The target never drives LAD outside SYNC, RDATA and PTAR0.

Optional Feature:
- Macro LPC_SYNC_WAIT_EN.
- Defined: 2 short-wait SYNC nibbles (4'h5) are inserted before the ready SYNC (4'h0) on both reads and writes. All later cycle numbers shift by +2. Capture of DataRd, RdStrobe and WrStrobe move with the ready SYNC, data and TAR phases. Abort rules apply during the wait nibbles.
- Undefined: single ready SYNC exactly as above.

Test Plan:
- Reset: PciReset=0 mid read at cycle 9 → LadOe=0, AddrReg=8'h00 immediately; after release, the bench waits for a new START.
- I/O read of 16'h080E with DataRd=8'hA5 → AddrReg=8'h0E in cycle 6; LAD = 0 (cycle 8), 5 (9), A (10), F (11); LadOe falls in cycle 12; RdStrobe high in cycle 10 only.
- I/O write of 8'h3C to 16'h0801 → DataWr=8'h3C and AddrReg=8'h01 with WrStrobe high for cycle 10 only; LAD=0 (10), F (11).
- Miss at 16'h0820, plus CYCTYPE 4'h4 → no LadOe at any point; AddrReg unchanged; no strobes.
- LFrame_n=0 with LadIn=0 during cycle 7 of a write → no WrStrobe; the new cycle decodes correctly from the next clock.
- With LPC_SYNC_WAIT_EN: read of 16'h0800 → LAD = 5, 5, 0, data low, data high, F in cycles 8–13.
